// File: rtl/inst_fetch_buffer_if.sv
// Fetch-stage bundle: instruction-memory request/response, EX redirect and the decode handshake.
// master = the fetch buffer, slave = the surrounding pipeline and instruction memory.
interface inst_fetch_buffer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// RV64 IF stage: owns the PC, issues in-order credit-limited fetches and queues returned words for decode.
// Optional performance counters are compiled in when IF_PERF_CNT_EN is defined.
module inst_fetch_buffer #(
    parameter logic [63:0] PC_RESET  = 64'h0,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_buffer_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_drop_cnt
`endif
);
    localparam int unsigned   AW      = $clog2(BUF_DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [63:0]   pc_q, pc_d;
    logic [63:0]   resp_pc_q, resp_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   entry_inst [BUF_DEPTH];
    logic [63:0]   entry_pc   [BUF_DEPTH];

    logic          redirect;
    logic [63:0]   redirect_base;
    logic          credit_ok;
    logic          req_valid;
    logic          req_fire;
    logic          resp_take;
    logic          resp_discard;
    logic          push;
    logic          head_valid;
    logic          pop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Handshake decode. count + outstanding never exceeds BUF_DEPTH, so every
    // issued request is guaranteed a FIFO slot when its response returns.
    always_comb begin
        redirect      = bus.redirect_valid;
        redirect_base = {bus.redirect_pc[63:2], 2'b00};
        credit_ok     = ({1'b0, count_q} + {1'b0, outstanding_q}) < {1'b0, DEPTH_C};
        req_valid     = !rst && !redirect && credit_ok;
        req_fire      = req_valid && bus.imem_req_ready;
        resp_take     = bus.imem_resp_valid && (outstanding_q != '0);
        resp_discard  = resp_take && (redirect || (drop_q != '0));
        push          = resp_take && !resp_discard;
        head_valid    = (count_q != '0);
        pop           = head_valid && bus.if_ready && !redirect;
    end

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_take);

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = redirect_base;
            resp_pc_d = redirect_base;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            drop_d    = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 64'd4;
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                resp_pc_d = resp_pc_q + 64'd4;
            end
            if (resp_discard) begin
                drop_d = drop_q - CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RESET;
            resp_pc_q     <= PC_RESET;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Payload storage needs no reset: an entry is only read while count says it holds data.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [31:0] inst_q;
            logic [63:0] pc_tag_q;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == AW'(gi))) begin
                    inst_q   <= bus.imem_resp_data;
                    pc_tag_q <= resp_pc_q;
                end
            end

            assign entry_inst[gi] = inst_q;
            assign entry_pc[gi]   = pc_tag_q;
        end
    endgenerate

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = head_valid;
    assign bus.if_inst        = head_valid ? entry_inst[rd_ptr_q] : NOP;
    assign bus.if_pc          = head_valid ? entry_pc[rd_ptr_q] : 64'h0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    // Drops include the response discarded in the redirect cycle itself.
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(pop);
        perf_drop_d  = perf_drop_q + 32'(resp_discard);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: queue-based reference of the fetch stream driven by random and
// directed stimulus; the memory model answers in order with data derived from the address.
module tb_inst_fetch_buffer;
    localparam logic [63:0] PC_RST = 64'h1000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk;
    logic rst;
    inst_fetch_buffer_if bus();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    inst_fetch_buffer #(.PC_RESET(PC_RST), .BUF_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference: program-order view of what memory owes and what decode should see.
    logic [63:0] m_pc;
    logic [63:0] mem_q[$];
    logic [63:0] m_fifo[$];
    int          m_drop;
    logic [31:0] m_fetch;
    logic [31:0] m_dropc;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return {a[17:2], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic exp_req_valid();
        return !bus.redirect_valid && ((m_fifo.size() + mem_q.size()) < DEPTH);
    endfunction

    function automatic logic [63:0] exp_pc();
        return (m_fifo.size() != 0) ? m_fifo[0] : 64'h0;
    endfunction

    function automatic logic [31:0] exp_inst();
        return (m_fifo.size() != 0) ? memfn(m_fifo[0]) : NOP;
    endfunction

    task automatic m_reset();
        m_pc = PC_RST;
        mem_q.delete();
        m_fifo.delete();
        m_drop = 0;
        m_fetch = '0;
        m_dropc = '0;
    endtask

    task automatic set_in(input bit rdy, input bit ifr, input bit resp_en,
                          input bit redir, input logic [63:0] rpc, input bit spur);
        bus.imem_req_ready = rdy;
        bus.if_ready       = ifr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (resp_en && mem_q.size() > 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memfn(mem_q[0]);
        end else begin
            bus.imem_resp_valid = spur && (mem_q.size() == 0);
            bus.imem_resp_data  = $urandom;
        end
        #1;
    endtask

    task automatic advance();
        bit fire, resp, pop;
        logic [63:0] a;
        fire = exp_req_valid() && bus.imem_req_ready;
        resp = bus.imem_resp_valid && (mem_q.size() > 0);
        pop  = (m_fifo.size() > 0) && bus.if_ready;
        @(posedge clk);
        if (resp) begin
            a = mem_q.pop_front();
            if (bus.redirect_valid || m_drop > 0) begin
                m_dropc += 32'd1;
                if (!bus.redirect_valid) m_drop--;
            end else begin
                m_fifo.push_back(a);
            end
        end
        if (bus.redirect_valid) begin
            m_fifo.delete();
            m_pc   = {bus.redirect_pc[63:2], 2'b00};
            m_drop = mem_q.size();
        end else begin
            if (pop) begin
                void'(m_fifo.pop_front());
                m_fetch += 32'd1;
            end
            if (fire) begin
                mem_q.push_back(m_pc);
                m_pc += 64'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic quiesce();
        repeat (6) begin
            set_in(0, 1, 1, 0, 64'h0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        set_in(1, 1, 1, 0, 64'h0, 0);
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got %b exp 0", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_req_addr !== PC_RST) begin n_bad++; $display("FAIL rst_addr got %h exp %h", bus.imem_req_addr, PC_RST); end
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid got %b exp 0", bus.if_valid); end
        n_cmp++; if (bus.if_inst !== NOP) begin n_bad++; $display("FAIL rst_if_inst got %h exp %h", bus.if_inst, NOP); end
        n_cmp++; if (bus.if_pc !== 64'h0) begin n_bad++; $display("FAIL rst_if_pc got %h exp 0", bus.if_pc); end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (perf_fetch_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_drop_cnt); end
`endif
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_req got %b exp 1", bus.imem_req_valid); end
        advance();
        $display("reset: released, first request at %h", PC_RST);
    endtask

    task automatic test_stream();
        logic [63:0] seq = PC_RST;
        int pops = 0;
        repeat (24) begin
            set_in(1, 1, 1, 0, 64'h0, 0);
            n_cmp++; if (bus.imem_req_valid !== exp_req_valid()) begin n_bad++; $display("FAIL stream_req_valid t=%0t got %b exp %b", $time, bus.imem_req_valid, exp_req_valid()); end
            n_cmp++; if (bus.imem_req_addr !== m_pc) begin n_bad++; $display("FAIL stream_addr t=%0t got %h exp %h", $time, bus.imem_req_addr, m_pc); end
            n_cmp++; if (bus.if_valid !== (m_fifo.size() != 0)) begin n_bad++; $display("FAIL stream_if_valid t=%0t got %b exp %b", $time, bus.if_valid, m_fifo.size() != 0); end
            n_cmp++; if (bus.if_inst !== exp_inst()) begin n_bad++; $display("FAIL stream_if_inst t=%0t got %h exp %h", $time, bus.if_inst, exp_inst()); end
            if (bus.if_valid === 1'b1) begin
                n_cmp++; if (bus.if_pc !== seq) begin n_bad++; $display("FAIL stream_order t=%0t got %h exp %h", $time, bus.if_pc, seq); end
                seq += 64'd4;
                pops++;
            end
            advance();
        end
        $display("stream: %0d instructions delivered in order from %h", pops, PC_RST);
    endtask

    task automatic test_stall();
        int fires = 0;
        logic [63:0] acc[$];
        logic [63:0] got[$];
        quiesce();
        repeat (10) begin
            set_in(1, 0, 1, 0, 64'h0, 0);
            if (bus.imem_req_valid === 1'b1) begin
                fires++;
                acc.push_back(bus.imem_req_addr);
            end
            advance();
        end
        set_in(1, 0, 1, 0, 64'h0, 0);
        n_cmp++; if (fires != DEPTH) begin n_bad++; $display("FAIL stall_accepted got %0d exp %0d", fires, DEPTH); end
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_credit got %b exp 0", bus.imem_req_valid); end
        repeat (6) begin
            set_in(0, 1, 1, 0, 64'h0, 0);
            if (bus.if_valid === 1'b1) begin
                got.push_back(bus.if_pc);
                n_cmp++; if (bus.if_inst !== memfn(bus.if_pc)) begin n_bad++; $display("FAIL stall_data got %h exp %h", bus.if_inst, memfn(bus.if_pc)); end
            end
            advance();
        end
        n_cmp++; if (got.size() != acc.size()) begin n_bad++; $display("FAIL stall_count got %0d exp %0d", got.size(), acc.size()); end
        for (int i = 0; i < acc.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== acc[i]) begin n_bad++; $display("FAIL stall_order[%0d] got %h exp %h", i, got[i], acc[i]); end
        end
        $display("stall: %0d requests held, %0d delivered after release", fires, got.size());
    endtask

    task automatic test_redirect();
        bit seen = 0;
        quiesce();
        repeat (2) begin
            set_in(1, 1, 0, 0, 64'h0, 0);
            advance();
        end
        set_in(1, 1, 0, 0, 64'h0, 0);
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_two_inflight got %b exp 0", bus.imem_req_valid); end
        set_in(1, 1, 0, 1, 64'h2002, 0);
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_no_req got %b exp 0", bus.imem_req_valid); end
        advance();
        set_in(1, 1, 1, 0, 64'h0, 0);
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_if_valid got %b exp 0", bus.if_valid); end
        n_cmp++; if (bus.imem_req_addr !== 64'h2000) begin n_bad++; $display("FAIL redir_addr got %h exp 2000", bus.imem_req_addr); end
        for (int i = 0; i < 12 && !seen; i++) begin
            if (i > 0) set_in(1, 1, 1, 0, 64'h0, 0);
            if (bus.if_valid === 1'b1) begin
                seen = 1;
                n_cmp++; if (bus.if_pc !== 64'h2000) begin n_bad++; $display("FAIL redir_first_pc got %h exp 2000", bus.if_pc); end
                n_cmp++; if (bus.if_inst !== memfn(64'h2000)) begin n_bad++; $display("FAIL redir_first_inst got %h exp %h", bus.if_inst, memfn(64'h2000)); end
            end
            advance();
        end
        if (!seen) begin n_cmp++; n_bad++; $display("FAIL redir_timeout got no if_valid exp pc 2000"); end
        $display("redirect: two in-flight responses dropped, restart at 2000");
    endtask

    task automatic test_redirect_resp();
        logic [63:0] tgt[2] = '{64'h0000_0000_0000_3000, 64'h0000_0000_0000_4444};
        for (int ph = 0; ph < 2; ph++) begin
            bit seen = 0;
            quiesce();
            set_in(1, 0, 0, 0, 64'h0, 0); advance();
            set_in(1, 0, ph == 0, 0, 64'h0, 0); advance();
            set_in(1, 1, 1, 1, tgt[ph], 0);
            n_cmp++; if (bus.if_valid !== (ph == 0)) begin n_bad++; $display("FAIL rr%0d_head got %b exp %b", ph, bus.if_valid, ph == 0); end
            n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rr%0d_no_req got %b exp 0", ph, bus.imem_req_valid); end
            advance();
            set_in(1, 1, 1, 0, 64'h0, 0);
            n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL rr%0d_if_valid got %b exp 0", ph, bus.if_valid); end
            n_cmp++; if (bus.imem_req_addr !== {tgt[ph][63:2], 2'b00}) begin n_bad++; $display("FAIL rr%0d_addr got %h exp %h", ph, bus.imem_req_addr, {tgt[ph][63:2], 2'b00}); end
            for (int i = 0; i < 12 && !seen; i++) begin
                if (i > 0) set_in(1, 1, 1, 0, 64'h0, 0);
                if (bus.if_valid === 1'b1) begin
                    seen = 1;
                    n_cmp++; if (bus.if_pc !== {tgt[ph][63:2], 2'b00}) begin n_bad++; $display("FAIL rr%0d_first_pc got %h exp %h", ph, bus.if_pc, {tgt[ph][63:2], 2'b00}); end
                end
                advance();
            end
            if (!seen) begin n_cmp++; n_bad++; $display("FAIL rr%0d_timeout got no if_valid exp pc %h", ph, tgt[ph]); end
            $display("redirect+resp phase %0d: restart at %h", ph, {tgt[ph][63:2], 2'b00});
        end
    endtask

    task automatic test_req_stall();
        logic [63:0] addr0;
        bit seen = 0;
        quiesce();
        addr0 = bus.imem_req_addr;
        repeat (5) begin
            set_in(0, 1, 1, 0, 64'h0, 0);
            n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid got %b exp 1", bus.imem_req_valid); end
            n_cmp++; if (bus.imem_req_addr !== addr0) begin n_bad++; $display("FAIL hold_addr got %h exp %h", bus.imem_req_addr, addr0); end
            advance();
        end
        set_in(0, 1, 0, 0, 64'h0, 1);
        advance();
        set_in(0, 1, 0, 0, 64'h0, 0);
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL spur_if_valid got %b exp 0", bus.if_valid); end
        n_cmp++; if (bus.imem_req_addr !== addr0) begin n_bad++; $display("FAIL spur_addr got %h exp %h", bus.imem_req_addr, addr0); end
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL spur_credit got %b exp 1", bus.imem_req_valid); end
        advance();
        for (int i = 0; i < 8 && !seen; i++) begin
            set_in(1, 1, 1, 0, 64'h0, 0);
            if (bus.if_valid === 1'b1) begin
                seen = 1;
                n_cmp++; if (bus.if_pc !== addr0) begin n_bad++; $display("FAIL spur_first_pc got %h exp %h", bus.if_pc, addr0); end
            end
            advance();
        end
        if (!seen) begin n_cmp++; n_bad++; $display("FAIL spur_timeout got no if_valid exp pc %h", addr0); end
        $display("req stall: addr %h held 5 cycles, spurious response ignored", addr0);
    endtask

    task automatic test_random(input int cycles);
        int redirs = 0;
        for (int c = 0; c < cycles; c++) begin
            bit redir = ($urandom_range(0, 15) == 0);
            logic [63:0] rpc = ($urandom_range(0, 2) == 0) ? (64'hFFFF_FFFF_FFFF_FFF4 | 64'($urandom_range(0, 3)))
                                                            : {32'($urandom), 32'($urandom)};
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   redir, rpc, $urandom_range(0, 7) == 0);
            redirs += int'(redir);
            n_cmp++; if (bus.imem_req_valid !== exp_req_valid()) begin n_bad++; $display("FAIL rnd_req_valid t=%0t got %b exp %b", $time, bus.imem_req_valid, exp_req_valid()); end
            n_cmp++; if (bus.imem_req_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr t=%0t got %h exp %h", $time, bus.imem_req_addr, m_pc); end
            n_cmp++; if (bus.if_valid !== (m_fifo.size() != 0)) begin n_bad++; $display("FAIL rnd_if_valid t=%0t got %b exp %b", $time, bus.if_valid, m_fifo.size() != 0); end
            n_cmp++; if (bus.if_pc !== exp_pc()) begin n_bad++; $display("FAIL rnd_if_pc t=%0t got %h exp %h", $time, bus.if_pc, exp_pc()); end
            n_cmp++; if (bus.if_inst !== exp_inst()) begin n_bad++; $display("FAIL rnd_if_inst t=%0t got %h exp %h", $time, bus.if_inst, exp_inst()); end
`ifdef IF_PERF_CNT_EN
            n_cmp++; if (perf_fetch_cnt !== m_fetch) begin n_bad++; $display("FAIL rnd_perf_fetch got %0d exp %0d", perf_fetch_cnt, m_fetch); end
            n_cmp++; if (perf_drop_cnt !== m_dropc) begin n_bad++; $display("FAIL rnd_perf_drop got %0d exp %0d", perf_drop_cnt, m_dropc); end
`endif
            advance();
        end
        $display("random: %0d cycles, %0d redirects, %0d fetched, %0d dropped", cycles, redirs, m_fetch, m_dropc);
    endtask

    task automatic test_reset_mid();
        test_random(30);
        set_in(1, 1, 1, 0, 64'h0, 0);
        rst = 1'b1;
        #1;
        m_reset();
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_valid got %b exp 0", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_req_addr !== PC_RST) begin n_bad++; $display("FAIL mid_addr got %h exp %h", bus.imem_req_addr, PC_RST); end
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_bad++; $display("FAIL mid_if_valid got %b exp 0", bus.if_valid); end
        n_cmp++; if (bus.if_inst !== NOP) begin n_bad++; $display("FAIL mid_if_inst got %h exp %h", bus.if_inst, NOP); end
`ifdef IF_PERF_CNT_EN
        n_cmp++; if (perf_fetch_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin n_bad++; $display("FAIL mid_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_drop_cnt); end
`endif
        @(negedge clk);
        set_in(1, 1, 1, 0, 64'h0, 0);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL mid_restart got %b exp 1", bus.imem_req_valid); end
        advance();
        $display("reset mid-run: state cleared, refetching from %h", PC_RST);
        test_random(40);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.if_ready        = 1'b0;
        m_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_resp();
        test_req_stall();
        test_random(600);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
